lfsr_run_ctrl: RTL
==================

LFSR_RUN_CTRL -- requirements
Module: lfsr_run_ctrl

Interface
REQ-001 SHALL have parameter NUM_RUNS, default 4, number of LFSR periods per test (1..255).
REQ-002 SHALL have parameter TIMEOUT, default 65535, maximum ticks allowed per run before error.
REQ-003 SHALL have parameter W, default 32, width of ones/zeros counts and sums.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous reset, active-high (asserted = 1).
REQ-006 SHALL have port tick  input  1  one-clk enable strobe from the clock divider; the LFSR and counter advance only on tick cycles.
REQ-007 SHALL have port start  input  1  start a test of NUM_RUNS runs.
REQ-008 SHALL have port abort  input  1  cancel the test in progress.
REQ-009 SHALL have port max_tick  input  1  LFSR end-of-period flag.
REQ-010 SHALL have port ones_in  input  W  counter ones total for the current run.
REQ-011 SHALL have port zeros_in  input  W  counter zeros total for the current run.
REQ-012 SHALL have port sh_en  output  1  LFSR shift enable.
REQ-013 SHALL have port cnt_clr  output  1  counter clear pulse.
REQ-014 SHALL have port busy  output  1  test in progress.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port error  output  1  sticky timeout flag for the last test.
REQ-017 SHALL have port run_idx  output  8  index of the current or last run.
REQ-018 SHALL have ports ones_sum, zeros_sum  output  W  accumulated totals.

Function
REQ-019 SHALL implement states IDLE, CLEAR, RUN, CAPTURE, DONE; outputs are decoded from the registered state.
REQ-020 IDLE: start=1 and abort=0 SHALL move to CLEAR next clk, zero ones_sum, zeros_sum, run_idx and error; start in any other state SHALL be ignored.
REQ-021 CLEAR SHALL assert cnt_clr for exactly one clk, reset the tick timer, then enter RUN.
REQ-022 RUN SHALL hold sh_en=1; sh_en SHALL be 0 in every other state.
REQ-023 RUN: tick=1 and max_tick=1 in the same cycle SHALL move to CAPTURE next clk; max_tick without tick SHALL be ignored.
REQ-024 RUN: the timer SHALL count tick cycles; when the count reaches TIMEOUT with no qualifying max_tick, the block SHALL set error=1 and enter DONE; if max_tick and timeout coincide, CAPTURE wins.
REQ-025 CAPTURE (one clk) SHALL add ones_in and zeros_in to the sums, saturating at 2^W-1.
REQ-026 CAPTURE: if run_idx = NUM_RUNS-1, the next state SHALL be DONE; otherwise run_idx increments and the next state is CLEAR.
REQ-027 DONE SHALL assert done for exactly one clk, then return to IDLE.
REQ-028 busy SHALL be 1 in CLEAR, RUN, CAPTURE and DONE.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE next clk: no done pulse, sums and run_idx held, error unchanged.
REQ-030 start and abort asserted together in IDLE SHALL leave the block in IDLE; abort wins.
REQ-031 Sums, run_idx and error SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-032 rst_n=1 SHALL force, on the next clk: state IDLE, sh_en=0, cnt_clr=0, busy=0, done=0, error=0, run_idx=0, sums=0, timer=0.
REQ-033 Reset mid-test SHALL take priority over abort, start, tick and every transition.

Structure
REQ-034 Shared package lfsr_ctrl_pkg SHALL hold the state enum, the run_idx width (8), and the default TIMEOUT and NUM_RUNS constants.
REQ-035 The tick timer SHALL be a sub-module tick_timer (clear, tick-qualified increment, expired flag at TIMEOUT).
REQ-036 Expected implementation size: 120-400 lines of RTL.

Verification
REQ-037 NUM_RUNS=2, tick every 4 clk, max_tick on the 15th tick of each run, ones_in=8, zeros_in=7 -> two cnt_clr pulses, done once, ones_sum=16, zeros_sum=14, error=0.
REQ-038 TIMEOUT=10, max_tick never asserted -> DONE after 10 ticks in RUN, error=1, ones_sum=0, run_idx=0.
REQ-039 abort asserted 3 clk into RUN of run 1 -> IDLE next clk, sh_en=0, busy=0, no done pulse, sums keep the run-0 values.
REQ-040 W=4, ones_in=9 over 2 runs -> ones_sum saturates at 15.
REQ-041 start and abort together in IDLE -> stays IDLE, busy=0; rst_n during CAPTURE -> all outputs 0 next clk.
REQ-042 max_tick=1 with tick=0 in RUN -> no transition; transition occurs only on the next cycle where tick and max_tick are both 1.

Source files
------------

// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and constants for the LFSR run controller and its tick timer.
package lfsr_ctrl_pkg;

  localparam int unsigned RunIdxW        = 8;
  localparam int unsigned DefaultTimeout = 65535;
  localparam int unsigned DefaultNumRuns = 4;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StCapture,
    StDone
  } state_t;

endpackage

// File: rtl/tick_timer.sv
// Counts tick-qualified cycles; expired flags the tick that brings the count to TIMEOUT.
module tick_timer #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] count_q;

  // Combinational so the controller can leave RUN on the very tick that hits the limit.
  assign expired = inc && (count_q == LastCnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != MaxCnt)) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_run_ctrl.sv
// Sequences NUM_RUNS LFSR periods, accumulating counter totals with saturation and a tick timeout.
module lfsr_run_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter int unsigned NUM_RUNS = DefaultNumRuns,
  parameter int unsigned TIMEOUT  = DefaultTimeout,
  parameter int unsigned W        = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               start,
  input  logic               abort,
  input  logic               max_tick,
  input  logic [W-1:0]       ones_in,
  input  logic [W-1:0]       zeros_in,
  output logic               sh_en,
  output logic               cnt_clr,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [RunIdxW-1:0] run_idx,
  output logic [W-1:0]       ones_sum,
  output logic [W-1:0]       zeros_sum
);

  localparam logic [RunIdxW-1:0] LastRun = RunIdxW'(NUM_RUNS - 1);

  state_t     state_q;
  logic       timer_clear;
  logic       timer_inc;
  logic       timer_expired;
  logic [W:0] ones_add;
  logic [W:0] zeros_add;
  logic [W-1:0] ones_next;
  logic [W-1:0] zeros_next;

  assign timer_clear = (state_q == StClear);
  assign timer_inc   = (state_q == StRun) && tick;

  tick_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_tick_timer (
    .clk    (clk),
    .rst    (rst_n),
    .clear  (timer_clear),
    .inc    (timer_inc),
    .expired(timer_expired)
  );

  always_comb begin
    ones_add   = {1'b0, ones_sum} + {1'b0, ones_in};
    zeros_add  = {1'b0, zeros_sum} + {1'b0, zeros_in};
    ones_next  = ones_add[W] ? '1 : ones_add[W-1:0];
    zeros_next = zeros_add[W] ? '1 : zeros_add[W-1:0];
  end

  // rst_n is an active-high synchronous reset despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= StIdle;
      error     <= 1'b0;
      run_idx   <= '0;
      ones_sum  <= '0;
      zeros_sum <= '0;
    end else if (abort) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StClear;
            error     <= 1'b0;
            run_idx   <= '0;
            ones_sum  <= '0;
            zeros_sum <= '0;
          end
        end
        StClear: state_q <= StRun;
        StRun: begin
          if (tick && max_tick) begin
            state_q <= StCapture;
          end else if (timer_expired) begin
            error   <= 1'b1;
            state_q <= StDone;
          end
        end
        StCapture: begin
          ones_sum  <= ones_next;
          zeros_sum <= zeros_next;
          if (run_idx == LastRun) begin
            state_q <= StDone;
          end else begin
            run_idx <= run_idx + 1'b1;
            state_q <= StClear;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sh_en   = (state_q == StRun);
  assign cnt_clr = (state_q == StClear);
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);

endmodule
